// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: opcodes, FSM states
// and the divide-by-zero quotient pattern.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP
    } state_e;

    // All-ones quotient for b=0; sliced to WIDTH by the user (WIDTH <= 64).
    localparam logic [63:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator (wraps, so -MIN == MIN).
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? ({WIDTH{1'b0}} - x) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO. Optional build macro
// MULDIV_EARLY_OUT_EN lets multiplies finish once the remaining multiplier is zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    state_e           state;
    op_e              op_q;
    logic [2*WIDTH-1:0] acc;      // product, or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] mcand;    // multiplicand, shifted left each step
    logic [WIDTH-1:0] mplier;     // multiplier (shifted right) or divisor
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;
    logic             div0;

    op_e              op_in;
    logic             signed_op;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             is_mul;

    assign op_in     = op_e'(op);
    assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign is_mul    = (op_q == OP_MULT) || (op_q == OP_MULTU);

    muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (.neg(signed_op & a[WIDTH-1]), .x(a), .y(abs_a));
    muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (.neg(signed_op & b[WIDTH-1]), .x(b), .y(abs_b));

    // Shift-add multiply step.
    logic [2*WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH-1:0]   mplier_nxt;
    assign mul_acc_nxt = acc + (mplier[0] ? mcand : {2*WIDTH{1'b0}});
    assign mplier_nxt  = mplier >> 1;

    // Restoring divide step: trial-subtract the divisor from {rem, next dividend bit}.
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_acc_nxt;
    assign div_diff    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mplier};
    assign div_acc_nxt = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                         : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    logic calc_last;
    assign calc_last = (cnt == CW'(1)) || (EARLY_OUT && is_mul && (mplier_nxt == '0));

    // Sign fix-up of the finished magnitudes. With b=0 the restoring loop leaves
    // |a| as remainder, so restoring sign(a) yields the raw dividend for hi.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    muldiv_negate #(.WIDTH(2*WIDTH)) u_neg_prod (.neg(sign_q), .x(acc),                 .y(prod_fix));
    muldiv_negate #(.WIDTH(WIDTH))   u_neg_quo  (.neg(sign_q), .x(acc[WIDTH-1:0]),      .y(quo_fix));
    muldiv_negate #(.WIDTH(WIDTH))   u_neg_rem  (.neg(sign_r), .x(acc[2*WIDTH-1:WIDTH]), .y(rem_fix));

    // NOTE: state is updated with non-blocking assignments so every register in
    // this block samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op_q   <= OP_MULT;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op_in;
                        acc    <= op_in[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
                        mcand  <= {{WIDTH{1'b0}}, abs_a};
                        mplier <= abs_b;
                        cnt    <= CW'(WIDTH);
                        sign_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sign_r <= signed_op & a[WIDTH-1];
                        div0   <= op_in[1] && (b == '0);
                        busy   <= 1'b1;
                        state  <= CALC;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_mul) begin
                        acc    <= mul_acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier_nxt;
                    end else begin
                        acc <= div_acc_nxt;
                    end
                    if (calc_last) state <= FIXUP;
                end
                FIXUP: begin
                    if (is_mul) begin
                        {hi, lo} <= prod_fix;
                    end else begin
                        hi <= rem_fix;
                        lo <= div0 ? DIV0_QUOTIENT[WIDTH-1:0] : quo_fix;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, handshake robustness and
// randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int WIDTH = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              hi_we;
    logic              lo_we;
    logic [WIDTH-1:0]  wdata;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint     sx;
        longint     sy;
        logic [63:0] r;
        int         q32;
        int         r32;
        case (o)
            2'b00: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                r  = 64'(sx * sy);
            end
            2'b01: r = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0)                                  r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    q32 = $signed(x) / $signed(y);
                    r32 = $signed(x) % $signed(y);
                    r   = {32'(r32), 32'(q32)};
                end
            end
            default: r = (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
        endcase
        return r;
    endfunction

    // Edges from the accepting edge (inclusive) to the edge that writes HI/LO.
    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] y);
        logic [31:0] m;
        int          n;
        if (!EARLY || o[1]) return WIDTH + 2;
        m = (o == 2'b00 && y[31]) ? (~y + 32'd1) : y;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return n + 2;
    endfunction

    // Waits (bounded) at negedges for a done pulse.
    task automatic wait_done(input string tag, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, ".done_seen"}, 64'(seen), 64'd1);
    endtask

    // Must be called just after a negedge; returns at the negedge where done is high.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
        int lat;
        int busy_cnt;
        int exp_lat;
        bit seen;
        exp_lat = exp_latency(o, y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        lat = 1; busy_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0; a = $urandom; b = $urandom;
                check({tag, ".done_low"}, 64'(done), 64'd0);
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(posedge clk);
            lat++;
        end
        check({tag, ".done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
            check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
            check({tag, ".busy_end"}, 64'(busy), 64'd0);
            check({tag, ".hi"}, 64'(hi), 64'(exp[63:32]));
            check({tag, ".lo"}, 64'(lo), 64'(exp[31:0]));
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen;
        int          n_done;
        int          n_busy;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] e;

        reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);

        run_op("mult",    2'b00, 32'h0000_0007, 32'hFFFF_FFFD, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        run_op("multu",   2'b01, 32'h0000_0007, 32'hFFFF_FFFD, {32'h0000_0006, 32'hFFFF_FFEB});
        run_op("divu",    2'b11, 32'h7654_3210, 32'h0123_4567, {32'h0000_0038, 32'h0000_0068});
        run_op("div",     2'b10, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div0",    2'b10, 32'h0123_4567, 32'h0000_0000, {32'h0123_4567, 32'hFFFF_FFFF});
        run_op("div0neg", 2'b10, 32'hFFFF_FFF0, 32'h0000_0000, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
        run_op("divu0",   2'b11, 32'h8765_4321, 32'h0000_0000, {32'h8765_4321, 32'hFFFF_FFFF});
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
        run_op("mult_b1", 2'b00, 32'h8000_0000, 32'h0000_0001, {32'hFFFF_FFFF, 32'h8000_0000});

        // Second start and HI/LO writes while busy must be ignored.
        start = 1'b1; op = 2'b01; a = 32'd7; b = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        e = model(2'b01, 32'd7, 32'hFFFF_FFFF);
        wait_done("busy_ignore", seen);
        check("busy_ignore.hi", 64'(hi), 64'(e[63:32]));
        check("busy_ignore.lo", 64'(lo), 64'(e[31:0]));
        n_done = 0; n_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        check("busy_ignore.no_extra_done", 64'(n_done), 64'd0);
        check("busy_ignore.no_extra_busy", 64'(n_busy), 64'd0);

        // Reset mid-CALC aborts the operation with no done pulse.
        start = 1'b1; op = 2'b11; a = 32'h7654_3210; b = 32'h0123_4567;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.hi", 64'(hi), 64'd0);
        check("abort.lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        n_done = 0; n_busy = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        check("abort.no_done", 64'(n_done), 64'd0);
        check("abort.no_busy", 64'(n_busy), 64'd0);
        check("abort.lo_kept", 64'(lo), 64'd0);

        // MTLO / MTHI in idle.
        lo_we = 1'b1; wdata = 32'h89AB_CDEF;
        @(posedge clk);
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo.lo", 64'(lo), 64'h89AB_CDEF);
        check("mtlo.hi", 64'(hi), 64'd0);
        hi_we = 1'b1; wdata = 32'h0000_1111;
        @(posedge clk);
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi.hi", 64'(hi), 64'h1111);
        check("mthi.lo", 64'(lo), 64'h89AB_CDEF);

        // start wins over a coincident MTHI.
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; hi_we = 1'b1; wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("start_wins.hi", 64'(hi), 64'h1111);
        check("start_wins.busy", 64'(busy), 64'd1);
        wait_done("start_wins", seen);
        check("start_wins.result_hi", 64'(hi), 64'd0);
        check("start_wins.result_lo", 64'(lo), 64'd6);

        // Randomized back-to-back operations.
        for (int i = 0; i < 200; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, model(ro, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
